// File: rtl/light_7_sequencer.sv
// light_7_sequencer: one-shot seven-LED pattern sequencer with four modes and programmable step rate.
module light_7_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [1:0] i_mode,
  output logic       o_led_1,
  output logic       o_led_2,
  output logic       o_led_3,
  output logic       o_led_4,
  output logic       o_led_5,
  output logic       o_led_6,
  output logic       o_led_7,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t r_state, w_state_nxt;
  logic [1:0] r_mode, w_mode_nxt;
  logic [3:0] r_step, w_step_nxt, w_last_step;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [6:0] r_led, w_led_nxt;
  logic [2:0] w_pos;
  logic r_busy, r_done, w_done_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_step_nxt  = r_step;
    w_tick_nxt  = r_tick;
    w_done_nxt  = 1'b0;
    w_last_step = r_mode == 2'd1 ? 4'd11 : r_mode == 2'd3 ? 4'd3 : 4'd6;
    if (r_state == IDLE) begin
      if (i_start && !i_stop) begin
        w_state_nxt = RUN;
        w_mode_nxt  = i_mode;
        w_step_nxt  = 4'd0;
        w_tick_nxt  = '0;
      end
    end else if (i_stop) begin
      w_state_nxt = IDLE;
      w_step_nxt  = 4'd0;
      w_tick_nxt  = '0;
    end else if (r_tick == TW'(TICK_DIV - 1)) begin
      w_tick_nxt = '0;
      if (r_step == w_last_step) begin
        w_state_nxt = IDLE;
        w_step_nxt  = 4'd0;
        w_done_nxt  = 1'b1;
      end else begin
        w_step_nxt = r_step + 4'd1;
      end
    end else begin
      w_tick_nxt = r_tick + TW'(1);
    end
    // bounce walks up to led_7 then back down, folding steps 7..11 onto 5..1
    w_pos = w_step_nxt < 4'd7 ? w_step_nxt[2:0] : 3'(4'd12 - w_step_nxt);
    w_led_nxt = w_state_nxt == IDLE ? 7'd0 :
                w_mode_nxt == 2'd0  ? 7'd1 << w_step_nxt[2:0] :
                w_mode_nxt == 2'd1  ? 7'd1 << w_pos :
                w_mode_nxt == 2'd2  ? 7'((8'd2 << w_step_nxt[2:0]) - 8'd1) :
                                      {7{~w_step_nxt[0]}};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_mode  <= 2'd0;
      r_step  <= 4'd0;
      r_tick  <= '0;
      r_led   <= 7'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_step  <= w_step_nxt;
      r_tick  <= w_tick_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_state_nxt == RUN;
      r_done  <= w_done_nxt;
    end
  end
  assign {o_led_7, o_led_6, o_led_5, o_led_4, o_led_3, o_led_2, o_led_1} = r_led;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

// File: tb/tb_light_7_sequencer.sv
// tb_light_7_sequencer: directed checks of three sequencer instances (TICK_DIV 3, 1, 2).
module tb_light_7_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic start_a, stop_a, start_b, stop_b, start_c, stop_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [6:0] led_a, led_b, led_c;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  int total = 0;
  int fails = 0;
  int pos[12] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2};

  always #5 clk = ~clk;

  light_7_sequencer #(.TICK_DIV(3)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_stop(stop_a), .i_mode(mode_a),
    .o_led_1(led_a[0]), .o_led_2(led_a[1]), .o_led_3(led_a[2]), .o_led_4(led_a[3]),
    .o_led_5(led_a[4]), .o_led_6(led_a[5]), .o_led_7(led_a[6]), .o_busy(busy_a), .o_done(done_a));
  light_7_sequencer #(.TICK_DIV(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_stop(stop_b), .i_mode(mode_b),
    .o_led_1(led_b[0]), .o_led_2(led_b[1]), .o_led_3(led_b[2]), .o_led_4(led_b[3]),
    .o_led_5(led_b[4]), .o_led_6(led_b[5]), .o_led_7(led_b[6]), .o_busy(busy_b), .o_done(done_b));
  light_7_sequencer #(.TICK_DIV(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_stop(stop_c), .i_mode(mode_c),
    .o_led_1(led_c[0]), .o_led_2(led_c[1]), .o_led_3(led_c[2]), .o_led_4(led_c[3]),
    .o_led_5(led_c[4]), .o_led_6(led_c[5]), .o_led_7(led_c[6]), .o_busy(busy_c), .o_done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: busy/done/leds got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {start_a, stop_a, start_b, stop_b, start_c, stop_c} = '0;
    {mode_a, mode_b, mode_c} = '0;
    #1;
    chk("reset_a", {busy_a, done_a, led_a}, 9'd0);
    chk("reset_b", {busy_b, done_b, led_b}, 9'd0);
    chk("reset_c", {busy_c, done_c, led_c}, 9'd0);
    #10 rst_n = 1'b1;
    tick();
    // chase, TICK_DIV=3
    start_a = 1'b1; mode_a = 2'd0;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 21; c++) begin
      chk("chase", {busy_a, done_a, led_a}, {2'b10, 7'd1 << (c / 3)});
      tick();
    end
    chk("chase_done", {busy_a, done_a, led_a}, {2'b01, 7'd0});
    tick();
    chk("chase_done_clear", {busy_a, done_a, led_a}, 9'd0);
    // bounce, TICK_DIV=1
    start_b = 1'b1; mode_b = 2'd1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("bounce", {busy_b, done_b, led_b}, {2'b10, 7'd1 << (pos[c] - 1)});
      tick();
    end
    chk("bounce_done", {busy_b, done_b, led_b}, {2'b01, 7'd0});
    tick();
    chk("bounce_done_clear", {busy_b, done_b, led_b}, 9'd0);
    // fill then back-to-back blink, TICK_DIV=2; mode/start wiggled mid blink
    start_c = 1'b1; mode_c = 2'd2;
    tick();
    start_c = 1'b0;
    for (int c = 0; c < 14; c++) begin
      chk("fill", {busy_c, done_c, led_c}, {2'b10, 7'((8'd2 << (c / 2)) - 8'd1)});
      tick();
    end
    chk("fill_done", {busy_c, done_c, led_c}, {2'b01, 7'd0});
    start_c = 1'b1; mode_c = 2'd3;
    tick();
    start_c = 1'b0;
    for (int c = 0; c < 8; c++) begin
      start_c = (c == 3);
      mode_c = c >= 3 ? 2'd0 : 2'd3;
      chk("blink", {busy_c, done_c, led_c}, {2'b10, ((c / 2) % 2 == 0) ? 7'h7f : 7'h00});
      tick();
    end
    start_c = 1'b0;
    chk("blink_done", {busy_c, done_c, led_c}, {2'b01, 7'd0});
    tick();
    chk("blink_done_clear", {busy_c, done_c, led_c}, 9'd0);
    // stop during chase step 3
    start_a = 1'b1; mode_a = 2'd0;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("stop_pre", {busy_a, done_a, led_a}, {2'b10, 7'b0001000});
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    chk("stop", {busy_a, done_a, led_a}, 9'd0);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("stop_no_done", {busy_a, done_a, led_a}, 9'd0);
    end
    start_a = 1'b1; stop_a = 1'b1;
    tick();
    chk("start_stop_idle", {busy_a, done_a, led_a}, 9'd0);
    tick();
    chk("start_stop_idle2", {busy_a, done_a, led_a}, 9'd0);
    start_a = 1'b0; stop_a = 1'b0;
    // stop on the edge the last blink step completes, TICK_DIV=1
    start_b = 1'b1; mode_b = 2'd3;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("final_pre", {busy_b, done_b, led_b}, {2'b10, 7'h00});
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    chk("final_stop", {busy_b, done_b, led_b}, 9'd0);
    tick();
    chk("final_stop_no_done", {busy_b, done_b, led_b}, 9'd0);
    // asynchronous reset mid-run, then clean restart
    start_a = 1'b1; mode_a = 2'd0;
    tick();
    start_a = 1'b0;
    tick();
    chk("pre_async", {busy_a, done_a, led_a}, {2'b10, 7'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy_a, done_a, led_a}, 9'd0);
    @(negedge clk);
    chk("async_rst_hold", {busy_a, done_a, led_a}, 9'd0);
    rst_n = 1'b1;
    start_a = 1'b1; mode_a = 2'd0;
    tick();
    start_a = 1'b0;
    chk("restart_step0", {busy_a, done_a, led_a}, {2'b10, 7'd1});
    for (int c = 0; c < 3; c++) tick();
    chk("restart_step1", {busy_a, done_a, led_a}, {2'b10, 7'd2});
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
